// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage state encoding.
// Used by the ALU control decoder and by alu_seq_exec.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SRL = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_t;

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative logical shift right: one bit per cycle, zero fill.
// The shift register and down-counter are loaded together; o_done flags the final shift.
module alu_serial_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_result
);

    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_count;

    assign o_busy   = (r_count != '0);
    assign o_done   = i_start && o_busy && (r_count == SHAMT_W'(1));
    // Value the register holds after this cycle's shift, so the caller can capture it on o_done.
    assign o_result = r_data >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_count <= i_shamt;
        end else if (i_start && o_busy) begin
            r_data  <= r_data >> 1;
            r_count <= r_count - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle ADD/SUB/AND/OR, iterative SRL.
// Define ALU_FLAGS_EN to add the Negative/Carry/Overflow outputs.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal_op
`ifdef ALU_FLAGS_EN
    ,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
`endif
);

    localparam int SHAMT_W = $clog2(WIDTH);

    exec_state_t        r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    logic               w_accept;
    logic               w_isSub;
    logic               w_isShift;
    logic               w_startShift;
    logic               w_opIllegal;
    logic [WIDTH-1:0]   w_bOp;
    logic [WIDTH-1:0]   w_addResult;
    logic [WIDTH-1:0]   w_opResult;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_shBusy;
    logic               w_shDone;
    logic [WIDTH-1:0]   w_shResult;

    // A finished result may be replaced in the same cycle it is consumed, so DONE also accepts.
    assign in_ready  = !reset && !w_shBusy &&
                       ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign illegal_op = r_illegal;

    assign w_isSub      = (ALUControl == ALU_SUB);
    assign w_bOp        = w_isSub ? ~SrcB : SrcB;
    assign w_shamt      = SrcB[SHAMT_W-1:0];
    assign w_startShift = w_isShift && (w_shamt != '0);

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic           w_isArith;
    logic           w_carry;
    logic           w_overflow;
    logic           r_carry;
    logic           r_overflow;

    assign w_sum       = {1'b0, SrcA} + {1'b0, w_bOp} + {{WIDTH{1'b0}}, w_isSub};
    assign w_addResult = w_sum[WIDTH-1:0];
    assign w_isArith   = (ALUControl == ALU_ADD) || w_isSub;
    assign w_carry     = w_isArith && w_sum[WIDTH];
    // Overflow when both effective operands share a sign that the result does not.
    assign w_overflow  = w_isArith && (SrcA[WIDTH-1] == w_bOp[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
    assign Negative    = r_result[WIDTH-1];
    assign Carry       = r_carry;
    assign Overflow    = r_overflow;
`else
    assign w_addResult = SrcA + w_bOp + {{(WIDTH-1){1'b0}}, w_isSub};
`endif

    always_comb begin
        w_opResult  = '0;
        w_opIllegal = 1'b0;
        w_isShift   = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: w_opResult = w_addResult;
            ALU_AND:          w_opResult = SrcA & SrcB;
            ALU_OR:           w_opResult = SrcA | SrcB;
            ALU_SRL: begin
                w_opResult = SrcA;
                w_isShift  = 1'b1;
            end
            default:          w_opIllegal = 1'b1;
        endcase
    end

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept && w_startShift),
        .i_start  (r_state == SHIFT),
        .i_data   (SrcA),
        .i_shamt  (w_shamt),
        .o_busy   (w_shBusy),
        .o_done   (w_shDone),
        .o_result (w_shResult)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept && w_startShift) begin
                        r_state <= SHIFT;
                    end else if (w_accept) begin
                        r_state   <= DONE;
                        r_result  <= w_opResult;
                        r_zero    <= (w_opResult == '0);
                        r_illegal <= w_opIllegal;
`ifdef ALU_FLAGS_EN
                        r_carry    <= w_carry;
                        r_overflow <= w_overflow;
`endif
                    end else if ((r_state == DONE) && out_ready) begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (w_shDone) begin
                        r_state   <= DONE;
                        r_result  <= w_shResult;
                        r_zero    <= (w_shResult == '0);
                        r_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
                        r_carry    <= 1'b0;
                        r_overflow <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec (default build or with ALU_FLAGS_EN).
module tb_alu_seq_exec;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             illegal_op;
`ifdef ALU_FLAGS_EN
    logic             Negative;
    logic             Carry;
    logic             Overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal_op (illegal_op)
`ifdef ALU_FLAGS_EN
        ,
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow)
`endif
    );

    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ordy);
        in_valid   = v;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = ordy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %0b exp 0", in_ready); end
        stepCycle();
        stepCycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL rst_result got %h exp 0", ALUResult); end
        checks++; if (Zero !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags got Zero=%0b ill=%0b exp 0 0", Zero, illegal_op); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_add();
        applyStimulus(1'b1, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %0b exp 1", out_valid); end
        checks++; if (ALUResult !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result got %h exp 80000000", ALUResult); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %0b exp 0", Zero); end
`ifdef ALU_FLAGS_EN
        checks++; if ({Negative, Carry, Overflow} !== 3'b101) begin errors++; $display("[TB] FAIL add_flags got NCV=%b exp 101", {Negative, Carry, Overflow}); end
`endif
        stepCycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 3'b001, 32'd5, 32'd5, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 3'b010, 32'h0000_FF00, 32'h0000_0FF0, 1'b1);
        checks++; if (out_valid !== 1'b1 || ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL sub_result got v=%0b %h exp v=1 0", out_valid, ALUResult); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero got %0b exp 1", Zero); end
`ifdef ALU_FLAGS_EN
        checks++; if ({Negative, Carry, Overflow} !== 3'b010) begin errors++; $display("[TB] FAIL sub_flags got NCV=%b exp 010", {Negative, Carry, Overflow}); end
`endif
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got %0b exp 1", in_ready); end
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        checks++; if (out_valid !== 1'b1 || ALUResult !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL and_result got v=%0b %h exp v=1 00000f00", out_valid, ALUResult); end
        checks++; if (Zero !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL and_flags got Zero=%0b ill=%0b exp 0 0", Zero, illegal_op); end
        stepCycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL and_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_srl_long();
        int lat = 0;
        int lowCnt = 0;
        applyStimulus(1'b1, 3'b101, 32'h8000_0000, 32'd31, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
            if (in_ready === 1'b0) lowCnt++;
            stepCycle();
        end
        checks++; if (lat != 32) begin errors++; $display("[TB] FAIL srl31_latency got %0d exp 32", lat); end
        checks++; if (lowCnt != 31) begin errors++; $display("[TB] FAIL srl31_busy got %0d exp 31", lowCnt); end
        checks++; if (ALUResult !== 32'h1) begin errors++; $display("[TB] FAIL srl31_result got %h exp 00000001", ALUResult); end
        stepCycle();
    endtask

    task automatic test_srl_zero();
        int lat = 0;
        applyStimulus(1'b1, 3'b101, 32'hDEAD_BEEF, 32'h0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        checks++; if (out_valid !== 1'b1 || ALUResult !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL srl0_result got v=%0b %h exp v=1 deadbeef", out_valid, ALUResult); end
        stepCycle();
        applyStimulus(1'b1, 3'b101, 32'hDEAD_BEEF, 32'h24, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
            stepCycle();
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL srl4_latency got %0d exp 5", lat); end
        checks++; if (ALUResult !== 32'h0DEA_DBEE) begin errors++; $display("[TB] FAIL srl4_result got %h exp 0deadbee", ALUResult); end
        stepCycle();
    endtask

    task automatic test_illegal();
        applyStimulus(1'b1, 3'b110, 32'h1234_5678, 32'h0000_5678, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 3'b000, 32'h1, 32'h1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1 ||
                illegal_op !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_hold cycle %0d got v=%0b r=%h z=%0b ill=%0b rdy=%0b exp 1 0 1 1 0",
                         i, out_valid, ALUResult, Zero, illegal_op, in_ready);
            end
            stepCycle();
        end
`ifdef ALU_FLAGS_EN
        checks++; if ({Carry, Overflow} !== 2'b00) begin errors++; $display("[TB] FAIL illegal_flags got CV=%b exp 00", {Carry, Overflow}); end
`endif
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        stepCycle();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_release got v=%0b rdy=%0b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_shift();
        int staleCnt = 0;
        applyStimulus(1'b1, 3'b101, 32'hF000_0000, 32'd20, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, 1'b1);
        repeat (5) stepCycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midshift_valid got %0b exp 0", out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready got %0b exp 0", in_ready); end
        stepCycle();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL midrst_out got v=%0b %h exp v=0 0", out_valid, ALUResult); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %0b exp 1", in_ready); end
        for (int i = 0; i < 30; i++) begin
            stepCycle();
            if (out_valid !== 1'b0) staleCnt++;
        end
        checks++; if (staleCnt != 0) begin errors++; $display("[TB] FAIL midrst_stale got %0d exp 0", staleCnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running exp finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_srl_long();
        test_srl_zero();
        test_illegal();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
